mem_wb_pipe_reg: RTL and testbench
==================================

// Module: mem_wb_pipe_reg
//
// PURPOSE
//   Parametrised MEM->WB pipeline register for the MIPS core, replacing the fixed 16-bit stage.
//   Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, r0 write gating,
//   early write-back data selection, a forwarding tap and a retired-instruction counter.
//   Sits between the data-memory stage and the register-file write port.
//
// PARAMETERS
//   DATA_W        16  width of memdata, aluresult and write-back data
//   REG_AW        3   register-file address width (regdst)
//   CNT_W         32  retired-instruction counter width (wraps modulo 2**CNT_W)
//   ZERO_REG_GATE 1   1: force regwrite=0 when regdst==0 at capture; 0: pass through unchanged
//
// PORTS
//   clk           in   1       system clock, rising edge
//   rst_n         in   1       synchronous reset, active low
//   flush         in   1       synchronous flush: drop every held and incoming entry
//   in_valid      in   1       MEM stage presents an entry
//   in_ready      out  1       stage can accept an entry this cycle
//   in_regwrite   in   1       entry writes the register file
//   in_memtoreg   in   1       1: write-back data = memdata; 0: write-back data = aluresult
//   in_memdata    in   DATA_W  load data
//   in_aluresult  in   DATA_W  ALU result
//   in_regdst     in   REG_AW  destination register
//   out_valid     out  1       WB entry valid
//   out_ready     in   1       register file or downstream consumes the entry
//   out_regwrite  out  1       write enable (gated, see BEHAVIOUR)
//   out_memtoreg  out  1       registered memtoreg, kept for debug
//   out_wbdata    out  DATA_W  selected write-back data
//   out_regdst    out  REG_AW  destination register
//   fwd_valid     out  1       out_valid & out_regwrite (combinational)
//   fwd_regdst    out  REG_AW  = out_regdst
//   fwd_data      out  DATA_W  = out_wbdata
//   retire_count  out  CNT_W   number of completed output handshakes
//
// BEHAVIOUR
//   - Reset (rst_n=0 at a clk edge): main and skid valid bits = 0; all data outputs = 0;
//     retire_count = 0; in_ready = 1 from the first edge after release. Reset overrides flush.
//   - Accept:  in_fire  = in_valid & in_ready.  Retire:  out_fire = out_valid & out_ready.
//   - in_ready = ~skid_valid. It is a pure register output, with no combinational path from out_ready.
//   - Capture at accept: wbdata = memtoreg ? memdata : aluresult;
//     regwrite_cap = in_regwrite & ~(ZERO_REG_GATE & (in_regdst == 0)).
//   - Main register (drives out_*) loads when it is empty or out_fire. It loads from skid if
//     skid_valid, else from the input if in_fire; otherwise it goes invalid.
//   - Skid register loads on in_fire when main stays occupied and is not draining.
//     It empties when its entry moves to main.
//   - Latency: 1 cycle from accept to out_valid with no backpressure. Throughput: 1 entry per cycle.
//   - Order is preserved. No entry is lost or duplicated under any out_ready pattern.
//   - Data outputs hold their value while out_valid & ~out_ready.
//   - Flush: at the next edge both valid bits = 0. An entry accepted in the flush cycle is
//     discarded. Data regs may keep stale values.
//   - Flush with out_fire in the same cycle: the retirement still counts.
//   - retire_count increments by 1 on each out_fire, including entries with regwrite=0.
//     It wraps from all-ones to 0 and is not cleared by flush.
//
// STRUCTURE
//   - Package mips_pipe_pkg holds DATA_W/REG_AW defaults and typedef wb_entry_t
//     {regwrite, memtoreg, wbdata, regdst}.
//   - Sub-module pipe_skid_buf: a generic 2-entry valid/ready skid buffer over a packed payload.
//     The top level does the capture mux, r0 gating, forwarding tap and counter.
//
// TESTING
//   - Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=1,
//     retire_count=0, out_wbdata=0.
//   - Stream with out_ready=1: 4 entries, memtoreg=1, memdata=16'hA5A5 / memtoreg=0, alu=16'h0042
//     -> each appears 1 cycle later with the correct wbdata; retire_count=4.
//   - Backpressure: out_ready=0 while offering 3 entries -> 2 accepted, in_ready=0, 3rd held at input.
//     Then out_ready=1 -> all 3 exit in order, no duplicates.
//   - Flush with main and skid full, plus out_fire in the same cycle -> next cycle out_valid=0,
//     in_ready=1, retire_count +1 only.
//   - r0 gating: regwrite=1, regdst=0 -> out_regwrite=0, fwd_valid=0. With ZERO_REG_GATE=0 ->
//     out_regwrite=1.
//   - Wrap: CNT_W=4, 17 retirements -> retire_count=1.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared widths and write-back entry type for the MIPS pipeline
package mips_pipe_pkg;

   localparam int WB_DATA_W = 16;
   localparam int WB_REG_AW = 3;
   localparam int WB_CNT_W  = 32;

   typedef struct packed {
      logic                 regwrite;
      logic                 memtoreg;
      logic [WB_DATA_W-1:0] wbdata;
      logic [WB_REG_AW-1:0] regdst;
   } wb_entry_t;

   localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry valid/ready skid buffer over a packed payload
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid_q, main_valid_d;
   logic [W-1:0] main_data_q,  main_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] skid_data_q,  skid_data_d;
   logic         in_fire, out_fire, main_load;

   // in_ready comes straight from a flop so out_ready never reaches it combinationally
   assign in_ready  = ~skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;

   assign in_fire   = in_valid & ~skid_valid_q;
   assign out_fire  = main_valid_q & out_ready;
   assign main_load = ~main_valid_q | out_fire;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (main_load) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
      // Data may go stale on flush; only the valid bits matter
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// rtl/mem_wb_pipe_reg.sv - MEM->WB pipeline register with skid buffer, r0 gating, forwarding tap and retire counter
module mem_wb_pipe_reg
   import mips_pipe_pkg::*;
#(
   parameter int DATA_W        = WB_DATA_W,
   parameter int REG_AW        = WB_REG_AW,
   parameter int CNT_W         = WB_CNT_W,
   parameter int ZERO_REG_GATE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_regwrite,
   input  logic              in_memtoreg,
   input  logic [DATA_W-1:0] in_memdata,
   input  logic [DATA_W-1:0] in_aluresult,
   input  logic [REG_AW-1:0] in_regdst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_regwrite,
   output logic              out_memtoreg,
   output logic [DATA_W-1:0] out_wbdata,
   output logic [REG_AW-1:0] out_regdst,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_regdst,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  retire_count
);

   localparam int PW = 2 + DATA_W + REG_AW;

   logic              gate_en;
   logic              regwrite_cap;
   logic [DATA_W-1:0] wbdata_cap;
   logic [PW-1:0]     cap_payload, out_payload;
   logic [CNT_W-1:0]  retire_q, retire_d;

   assign gate_en      = (ZERO_REG_GATE != 0);
   assign wbdata_cap   = in_memtoreg ? in_memdata : in_aluresult;
   // Writes to r0 are architecturally void, so drop the enable before it enters the pipe
   assign regwrite_cap = in_regwrite & ~(gate_en & (in_regdst == '0));
   assign cap_payload  = {regwrite_cap, in_memtoreg, wbdata_cap, in_regdst};

   pipe_skid_buf #(.W(PW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (cap_payload),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_payload)
   );

   assign {out_regwrite, out_memtoreg, out_wbdata, out_regdst} = out_payload;

   assign fwd_valid  = out_valid & out_regwrite;
   assign fwd_regdst = out_regdst;
   assign fwd_data   = out_wbdata;

   assign retire_d     = (out_valid & out_ready) ? retire_q + {{(CNT_W-1){1'b0}}, 1'b1} : retire_q;
   assign retire_count = retire_q;

   // Flush does not clear the counter; a retirement in the flush cycle still counts
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retire_q <= '0;
      end else begin
         retire_q <= retire_d;
      end
   end

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb/tb_mem_wb_pipe_reg.sv - directed self-checking bench for mem_wb_pipe_reg
module tb_mem_wb_pipe_reg;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic        in_regwrite, in_memtoreg;
   logic [15:0] in_memdata, in_aluresult;
   logic [2:0]  in_regdst;

   logic        in_ready, out_valid, out_regwrite, out_memtoreg, fwd_valid;
   logic [15:0] out_wbdata, fwd_data;
   logic [2:0]  out_regdst, fwd_regdst;
   logic [31:0] retire_count;

   logic        b_in_ready, b_out_valid, b_out_regwrite, b_out_memtoreg, b_fwd_valid;
   logic [15:0] b_out_wbdata, b_fwd_data;
   logic [2:0]  b_out_regdst, b_fwd_regdst;
   logic [3:0]  b_retire_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_wb_pipe_reg dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
      .in_memdata(in_memdata), .in_aluresult(in_aluresult), .in_regdst(in_regdst),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg),
      .out_wbdata(out_wbdata), .out_regdst(out_regdst),
      .fwd_valid(fwd_valid), .fwd_regdst(fwd_regdst), .fwd_data(fwd_data),
      .retire_count(retire_count)
   );

   mem_wb_pipe_reg #(.CNT_W(4), .ZERO_REG_GATE(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
      .in_memdata(in_memdata), .in_aluresult(in_aluresult), .in_regdst(in_regdst),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_regwrite(b_out_regwrite), .out_memtoreg(b_out_memtoreg),
      .out_wbdata(b_out_wbdata), .out_regdst(b_out_regdst),
      .fwd_valid(b_fwd_valid), .fwd_regdst(b_fwd_regdst), .fwd_data(b_fwd_data),
      .retire_count(b_retire_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic m2r,
                        input logic [15:0] md, input logic [15:0] alu, input logic [2:0] rd);
      in_valid     = v;
      in_regwrite  = rw;
      in_memtoreg  = m2r;
      in_memdata   = md;
      in_aluresult = alu;
      in_regdst    = rd;
   endtask

   logic [15:0] exp_wb [4];

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678, 3'd4);
      repeat (3) step();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_retire", retire_count, 32'd0);
      check("rst_wbdata", {16'd0, out_wbdata}, 32'd0);

      // Stream, no backpressure
      rst_n = 1'b1; out_ready = 1'b1;
      exp_wb[0] = 16'hA5A5; exp_wb[1] = 16'h0042; exp_wb[2] = 16'hA5A5; exp_wb[3] = 16'h0042;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, (i % 2 == 0), 16'hA5A5, 16'h0042, 3'(i + 1));
         step();
         check("stream_valid", {31'd0, out_valid}, 32'd1);
         check("stream_wbdata", {16'd0, out_wbdata}, {16'd0, exp_wb[i]});
         check("stream_regdst", {29'd0, out_regdst}, 32'(i + 1));
      end
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
      step();
      check("stream_drain_valid", {31'd0, out_valid}, 32'd0);
      check("stream_retire", retire_count, 32'd4);

      // Backpressure: A to main, B to skid, C held at input
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h000A, 3'd3); step();
      check("bp_ready_after_a", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h000B, 3'd3); step();
      check("bp_ready_after_b", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h000C, 3'd3); step();
      check("bp_ready_held", {31'd0, in_ready}, 32'd0);
      check("bp_hold_a", {16'd0, out_wbdata}, 32'h000A);
      out_ready = 1'b1; step();
      check("bp_out_b", {16'd0, out_wbdata}, 32'h000B);
      check("bp_ready_reopen", {31'd0, in_ready}, 32'd1);
      step();
      check("bp_out_c", {16'd0, out_wbdata}, 32'h000C);
      check("bp_valid_c", {31'd0, out_valid}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0); step();
      check("bp_no_dup", {31'd0, out_valid}, 32'd0);
      check("bp_retire", retire_count, 32'd7);

      // Flush with both entries full and an output handshake in the same cycle
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h000D, 3'd2); step();
      drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h000E, 3'd2); step();
      check("fl_full", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h000F, 3'd2);
      flush = 1'b1; out_ready = 1'b1; step();
      check("fl_valid", {31'd0, out_valid}, 32'd0);
      check("fl_ready", {31'd0, in_ready}, 32'd1);
      check("fl_retire", retire_count, 32'd8);
      step();
      check("fl_drop_incoming", {31'd0, out_valid}, 32'd0);
      flush = 1'b0;

      // r0 gating on both gate settings
      drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h00AB, 3'd0); step();
      check("r0_regwrite", {31'd0, out_regwrite}, 32'd0);
      check("r0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
      check("r0_nogate_regwrite", {31'd0, b_out_regwrite}, 32'd1);
      check("r0_nogate_fwd", {31'd0, b_fwd_valid}, 32'd1);
      drive(1'b1, 1'b1, 1'b1, 16'h0CDE, 16'h00AB, 3'd5); step();
      check("fwd_valid", {31'd0, fwd_valid}, 32'd1);
      check("fwd_regdst", {29'd0, fwd_regdst}, 32'd5);
      check("fwd_data", {16'd0, fwd_data}, 32'h0CDE);
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0); step();
      check("r0_retire", retire_count, 32'd10);
      check("r0_retire_b", {28'd0, b_retire_count}, 32'd10);

      // Counter wrap on the 4-bit instance
      rst_n = 1'b0; step(); rst_n = 1'b1;
      for (int k = 0; k < 17; k++) begin
         drive(1'b1, 1'b0, 1'b0, 16'h0, 16'(16'h0100 + k), 3'd1);
         step();
         if (k == 9) check("wrap_order", {16'd0, out_wbdata}, 32'h0109);
      end
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0); step();
      check("wrap_count_b", {28'd0, b_retire_count}, 32'd1);
      check("wrap_count_a", retire_count, 32'd17);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
